// File: rtl/fft_butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly on sign-magnitude Q8.8 samples:
// S1 operands, S2 real products plus delayed A, S3 results X0 = A + W*B, X1 = A - W*B.
module fft_butterfly_pipe #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a_re,
   input  logic [DATA_W-1:0] a_im,
   input  logic [DATA_W-1:0] b_re,
   input  logic [DATA_W-1:0] b_im,
   input  logic [DATA_W-1:0] w_re,
   input  logic [DATA_W-1:0] w_im,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] x0_re,
   output logic [DATA_W-1:0] x0_im,
   output logic [DATA_W-1:0] x1_re,
   output logic [DATA_W-1:0] x1_im,
   output logic              sat_flag,
   input  logic              sat_clear
);

   localparam int MAG_W  = DATA_W - 1;
   localparam int ACC_W  = DATA_W + 2;
   localparam int PROD_W = 2 * MAG_W;
   localparam int SHR_W  = PROD_W - FRAC_W;

   function automatic logic [ACC_W-1:0] sm_to_tc(input logic [DATA_W-1:0] x);
      logic [ACC_W-1:0] mag;
      mag = {{(ACC_W-MAG_W){1'b0}}, x[MAG_W-1:0]};
      return x[DATA_W-1] ? -mag : mag;
   endfunction

   // Returns {saturated, two's-complement product}; a zero magnitude negates to +0.
   function automatic logic [ACC_W:0] sm_mul(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
      logic [PROD_W-1:0] prod;
      logic [SHR_W-1:0]  shr;
      logic [ACC_W-1:0]  mag;
      logic              sat;
      prod = {{(PROD_W-MAG_W){1'b0}}, x[MAG_W-1:0]} * {{(PROD_W-MAG_W){1'b0}}, y[MAG_W-1:0]};
      shr  = prod[PROD_W-1:FRAC_W];
      sat  = |shr[SHR_W-1:MAG_W];
      mag  = {{(ACC_W-MAG_W){1'b0}}, (sat ? {MAG_W{1'b1}} : shr[MAG_W-1:0])};
      return {sat, ((x[DATA_W-1] ^ y[DATA_W-1]) ? -mag : mag)};
   endfunction

   function automatic logic [DATA_W:0] tc_to_sm(input logic [ACC_W-1:0] v);
      logic [ACC_W-1:0] mag;
      logic             sat;
      mag = v[ACC_W-1] ? -v : v;
      sat = |mag[ACC_W-1:MAG_W];
      return {sat, v[ACC_W-1], (sat ? {MAG_W{1'b1}} : mag[MAG_W-1:0])};
   endfunction

   logic              advance;
   logic [DATA_W-1:0] in_op [6];
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_op_q [6];
   logic [DATA_W-1:0] s1_op_d [6];
   logic              s2_valid_q, s2_valid_d;
   logic [ACC_W-1:0]  s2_a_q [2];
   logic [ACC_W-1:0]  s2_a_d [2];
   logic [ACC_W-1:0]  s2_p_q [4];
   logic [ACC_W-1:0]  s2_p_d [4];
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] x_q [4];
   logic [DATA_W-1:0] x_d [4];
   logic              sat_q, sat_d;

   logic [ACC_W-1:0]  mul_tc [4];
   logic [3:0]        mul_sat;
   logic [ACC_W-1:0]  p_re, p_im;
   logic [ACC_W-1:0]  sum_tc [4];
   logic [DATA_W-1:0] sum_sm [4];
   logic [3:0]        sum_sat;

   assign in_op[0] = a_re;
   assign in_op[1] = a_im;
   assign in_op[2] = b_re;
   assign in_op[3] = b_im;
   assign in_op[4] = w_re;
   assign in_op[5] = w_im;

   // Product order: br*wr, bi*wi, br*wi, bi*wr.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mul
         localparam int BX = 2 + (gi % 2);
         localparam int WY = (gi == 0 || gi == 3) ? 4 : 5;
         assign {mul_sat[gi], mul_tc[gi]} = sm_mul(s1_op_q[BX], s1_op_q[WY]);
      end
   endgenerate

   assign p_re = s2_p_q[0] - s2_p_q[1];
   assign p_im = s2_p_q[2] + s2_p_q[3];

   // Result order: x0_re, x0_im, x1_re, x1_im.
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sum
         logic [ACC_W-1:0] p_sel;
         assign p_sel = (gi % 2 == 0) ? p_re : p_im;
         if (gi < 2) begin : g_add
            assign sum_tc[gi] = s2_a_q[gi % 2] + p_sel;
         end else begin : g_sub
            assign sum_tc[gi] = s2_a_q[gi % 2] - p_sel;
         end
         assign {sum_sat[gi], sum_sm[gi]} = tc_to_sm(sum_tc[gi]);
      end
   endgenerate

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s2_valid_d  = s2_valid_q;
      s2_a_d      = s2_a_q;
      s2_p_d      = s2_p_q;
      out_valid_d = out_valid_q;
      x_d         = x_q;
      if (advance) begin
         s1_valid_d = in_valid;
         if (in_valid) s1_op_d = in_op;
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_a_d[0] = sm_to_tc(s1_op_q[0]);
            s2_a_d[1] = sm_to_tc(s1_op_q[1]);
            for (int i = 0; i < 4; i++) s2_p_d[i] = mul_tc[i];
         end
         out_valid_d = s2_valid_q;
         if (s2_valid_q) x_d = sum_sm;
      end
      // A saturation being registered this cycle overrides a simultaneous clear.
      sat_d = sat_clear ? 1'b0 : sat_q;
      if (advance && ((s1_valid_q && |mul_sat) || (s2_valid_q && |sum_sat))) sat_d = 1'b1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         for (int i = 0; i < 6; i++) s1_op_q[i] <= '0;
         for (int i = 0; i < 2; i++) s2_a_q[i] <= '0;
         for (int i = 0; i < 4; i++) begin
            s2_p_q[i] <= '0;
            x_q[i]    <= '0;
         end
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s2_valid_q  <= s2_valid_d;
         s2_a_q      <= s2_a_d;
         s2_p_q      <= s2_p_d;
         out_valid_q <= out_valid_d;
         x_q         <= x_d;
         sat_q       <= sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign x0_re     = x_q[0];
   assign x0_im     = x_q[1];
   assign x1_re     = x_q[2];
   assign x1_im     = x_q[3];
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Self-checking bench for fft_butterfly_pipe: directed vectors plus randomized
// streams scored against an integer-arithmetic model of the butterfly.
module tb_fft_butterfly_pipe;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b1, sat_clear = 1'b0;
   logic [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
   logic        in_ready, out_valid, sat_flag;
   logic [15:0] x0_re, x0_im, x1_re, x1_im;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];
   bit          model_sat;
   bit          stream_done;

   always #5 clk = ~clk;

   fft_butterfly_pipe dut (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
      .out_valid(out_valid), .out_ready(out_ready),
      .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
      .sat_flag(sat_flag), .sat_clear(sat_clear)
   );

   // Inputs only change just after a rising edge, so the falling edge sees settled handshakes.
   always @(negedge clk)
      if (n_rst && out_valid && out_ready) obs_q.push_back({x0_re, x0_im, x1_re, x1_im});

   function automatic int sm2i(input logic [15:0] x);
      int m;
      m = int'(x[14:0]);
      return x[15] ? -m : m;
   endfunction

   function automatic int mulm(input logic [15:0] x, input logic [15:0] y);
      int m;
      m = (int'(x[14:0]) * int'(y[14:0])) / 256;
      if (m > 32767) begin
         m = 32767;
         model_sat = 1'b1;
      end
      return (x[15] ^ y[15]) ? -m : m;
   endfunction

   function automatic logic [15:0] i2sm(input int v);
      int m;
      m = (v < 0) ? -v : v;
      if (m > 32767) begin
         m = 32767;
         model_sat = 1'b1;
      end
      return {(v < 0), m[14:0]};
   endfunction

   function automatic logic [63:0] model(input logic [15:0] ar, ai, br, bi, wr, wi);
      int pr, pi;
      pr = mulm(br, wr) - mulm(bi, wi);
      pi = mulm(br, wi) + mulm(bi, wr);
      return {i2sm(sm2i(ar) + pr), i2sm(sm2i(ai) + pi), i2sm(sm2i(ar) - pr), i2sm(sm2i(ai) - pi)};
   endfunction

   function automatic logic [15:0] rnd_sm();
      logic [15:0] r;
      r[15]   = 1'($urandom_range(0, 1));
      r[14:0] = ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 32767)) : 15'($urandom_range(0, 1023));
      return r;
   endfunction

   // Called just after a rising edge; returns just after the edge that accepted the operand.
   task automatic send(input logic [15:0] ar, ai, br, bi, wr, wi, output int cycles);
      bit done = 1'b0;
      a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
      in_valid = 1'b1;
      cycles = 0;
      for (int k = 0; k < 64 && !done; k++) begin
         #1;
         if (in_ready) begin
            exp_q.push_back(model(ar, ai, br, bi, wr, wi));
            done = 1'b1;
         end
         @(posedge clk); #1;
         cycles++;
      end
      in_valid = 1'b0;
      if (!done) cycles = -1;
   endtask

   task automatic wait_results(input int n, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_clear();
      sat_clear = 1'b1;
      @(posedge clk); #1;
      sat_clear = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests_run++;
      if ({x0_re, x0_im, x1_re, x1_im} !== 64'h0) begin
         tests_failed++; $display("FAIL reset_outputs: got %h expected 0", {x0_re, x0_im, x1_re, x1_im});
      end
      tests_run++;
      if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      $display("[TB] reset: out_valid=%b sat_flag=%b in_ready=%b", out_valid, sat_flag, in_ready);
      n_rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_latency();
      int c;
      exp_q.delete(); obs_q.delete();
      send(16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0100, 16'h0000, c);
      tests_run++;
      if (c != 1) begin tests_failed++; $display("FAIL basic_accept: got %0d cycles expected 1", c); end
      for (int k = 0; k < 2; k++) begin
         tests_run++;
         if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid[%0d]: got %b expected 0", k, out_valid); end
         @(posedge clk); #1;
      end
      tests_run++;
      if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_latency: got out_valid %b expected 1", out_valid); end
      tests_run++;
      if ({x0_re, x0_im, x1_re, x1_im} !== 64'h0180_0000_0080_0000) begin
         tests_failed++; $display("FAIL basic_result: got %h expected 0180000000800000", {x0_re, x0_im, x1_re, x1_im});
      end
      tests_run++;
      if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL basic_sat: got %b expected 0", sat_flag); end
      $display("[TB] basic: x0=(%h,%h) x1=(%h,%h)", x0_re, x0_im, x1_re, x1_im);
      @(posedge clk); #1;
   endtask

   task automatic test_minus_j();
      int c;
      bit ok;
      exp_q.delete(); obs_q.delete();
      send(16'h0000, 16'h0000, 16'h0300, 16'h0000, 16'h0000, 16'h8100, c);
      wait_results(1, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL minus_j_timeout: got 0 results expected 1"); return; end
      tests_run++;
      if (obs_q[0] !== 64'h0000_8300_0000_0300) begin
         tests_failed++; $display("FAIL minus_j_result: got %h expected 0000830000000300", obs_q[0]);
      end
      $display("[TB] minus_j: result %h", obs_q[0]);
   endtask

   task automatic test_saturation();
      int c;
      bit ok;
      exp_q.delete(); obs_q.delete();
      send(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 16'h0100, 16'h0000, c);
      wait_results(1, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL sat_timeout: got 0 results expected 1"); return; end
      tests_run++;
      if (obs_q[0] !== 64'h7FFF_0000_7D00_0000) begin
         tests_failed++; $display("FAIL sat_result: got %h expected 7fff00007d000000", obs_q[0]);
      end
      tests_run++;
      if (sat_flag !== 1'b1) begin tests_failed++; $display("FAIL sat_flag_set: got %b expected 1", sat_flag); end
      pulse_clear();
      tests_run++;
      if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL sat_flag_clear: got %b expected 0", sat_flag); end
      $display("[TB] saturation: result %h, flag after clear %b", obs_q[0], sat_flag);
   endtask

   task automatic test_neg_zero();
      int c;
      bit ok;
      exp_q.delete(); obs_q.delete();
      send(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, c);
      wait_results(1, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL neg_zero_timeout: got 0 results expected 1"); return; end
      tests_run++;
      if (obs_q[0] !== 64'h0) begin tests_failed++; $display("FAIL neg_zero_result: got %h expected 0", obs_q[0]); end
      tests_run++;
      if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL neg_zero_sat: got %b expected 0", sat_flag); end
      $display("[TB] neg_zero: result %h", obs_q[0]);
   endtask

   task automatic test_back_to_back();
      int          c;
      bit          ok;
      logic [63:0] held;
      exp_q.delete(); obs_q.delete();
      pulse_clear();
      model_sat = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            out_ready = 1'b0;
            held = {x0_re, x0_im, x1_re, x1_im};
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_in_ready_drop: got %b expected 0", in_ready); end
            for (int k = 0; k < 4; k++) begin
               @(posedge clk); #1;
               tests_run++;
               if (out_valid !== 1'b1 || {x0_re, x0_im, x1_re, x1_im} !== held) begin
                  tests_failed++;
                  $display("FAIL b2b_hold[%0d]: got valid %b data %h expected valid 1 data %h",
                           k, out_valid, {x0_re, x0_im, x1_re, x1_im}, held);
               end
            end
            out_ready = 1'b1;
         end
         send(rnd_sm(), rnd_sm(), rnd_sm(), rnd_sm(), rnd_sm(), rnd_sm(), c);
         tests_run++;
         if (c != 1) begin tests_failed++; $display("FAIL b2b_accept[%0d]: got %0d cycles expected 1", i, c); end
      end
      wait_results(8, ok);
      repeat (5) @(posedge clk);
      #1;
      tests_run++;
      if (!ok || obs_q.size() != 8) begin
         tests_failed++; $display("FAIL b2b_count: got %0d results expected 8", obs_q.size()); return;
      end
      for (int i = 0; i < 8; i++) begin
         tests_run++;
         $display("[TB] b2b %0d: got %h exp %h", i, obs_q[i], exp_q[i]);
         if (obs_q[i] !== exp_q[i]) begin
            tests_failed++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      tests_run++;
      if (sat_flag !== model_sat) begin tests_failed++; $display("FAIL b2b_sat: got %b expected %b", sat_flag, model_sat); end
   endtask

   task automatic test_random_stream();
      int  c;
      bit  ok;
      int  n = 30;
      exp_q.delete(); obs_q.delete();
      pulse_clear();
      model_sat = 1'b0;
      stream_done = 1'b0;
      fork
         begin
            for (int i = 0; i < n; i++) begin
               send(rnd_sm(), rnd_sm(), rnd_sm(), rnd_sm(), rnd_sm(), rnd_sm(), c);
               if (c < 0) begin
                  tests_run++; tests_failed++;
                  $display("FAIL rand_accept[%0d]: got no accept expected accept", i);
               end
            end
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_results(exp_q.size(), ok);
      repeat (5) @(posedge clk);
      #1;
      tests_run++;
      if (!ok || obs_q.size() != exp_q.size()) begin
         tests_failed++; $display("FAIL rand_count: got %0d results expected %0d", obs_q.size(), exp_q.size()); return;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         $display("[TB] rand %0d: got %h exp %h", i, obs_q[i], exp_q[i]);
         if (obs_q[i] !== exp_q[i]) begin
            tests_failed++; $display("FAIL rand_result[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      tests_run++;
      if (sat_flag !== model_sat) begin tests_failed++; $display("FAIL rand_sat: got %b expected %b", sat_flag, model_sat); end
   endtask

   task automatic test_reset_inflight();
      int c;
      exp_q.delete(); obs_q.delete();
      send(16'h0100, 16'h0200, 16'h0100, 16'h0000, 16'h0100, 16'h0000, c);
      send(16'h0300, 16'h0000, 16'h0080, 16'h0080, 16'h0100, 16'h0100, c);
      #2;
      n_rst = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || {x0_re, x0_im, x1_re, x1_im} !== 64'h0) begin
         tests_failed++;
         $display("FAIL inflight_reset: got valid %b data %h expected valid 0 data 0", out_valid, {x0_re, x0_im, x1_re, x1_im});
      end
      tests_run++;
      if (sat_flag !== 1'b0) begin tests_failed++; $display("FAIL inflight_sat: got %b expected 0", sat_flag); end
      @(posedge clk); #1;
      n_rst = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      tests_run++;
      if (obs_q.size() != 0 || out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL inflight_stale: got %0d results valid %b expected 0 results", obs_q.size(), out_valid);
      end
      $display("[TB] reset_inflight: stale results %0d", obs_q.size());
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_minus_j();
      test_saturation();
      test_neg_zero();
      test_back_to_back();
      test_random_stream();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
